// File: rtl/hazard_scoreboard_if.sv
// Bundles the ID-stage request and hazard-response signals for hazard_scoreboard.
// The master modport is the pipeline or bench side. The slave modport is the scoreboard side.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              freeze;
  logic              flush;
  logic              id_valid;
  logic              id_WB_En;
  logic              id_MEM_R_En;
  logic [ADDR_W-1:0] id_dest;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              src2_used;
  logic              stall;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output freeze, flush, id_valid, id_WB_En, id_MEM_R_En, id_dest, src1, src2, src2_used,
    input  stall, fwd_sel1, fwd_sel2, stall_cycles
  );

  modport slave (
    input  freeze, flush, id_valid, id_WB_En, id_MEM_R_En, id_dest, src1, src2, src2_used,
    output stall, fwd_sel1, fwd_sel2, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes in the EXE, MEM and WB slots and computes stall and forward selects for ID.
// Define FORWARD_EN to enable forwarding. Without it, any dependency on an in-flight write stalls.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_scoreboard_if.slave bus
);

  logic              r_exeValid, r_memValid, r_wbValid;
  logic [ADDR_W-1:0] r_exeDest, r_memDest, r_wbDest;
  logic              r_exeLoad, r_memLoad, r_wbLoad;
  logic [CNT_W-1:0]  r_stallCnt;

  logic w_m1E, w_m1M, w_m1W;
  logic w_m2E, w_m2M, w_m2W;
  logic w_stall;
  logic [1:0] w_sel1, w_sel2;
  logic w_src1Nz, w_src2Live;

  assign w_src1Nz   = (bus.src1 != '0);
  assign w_src2Live = bus.src2_used && (bus.src2 != '0);

  assign w_m1E = w_src1Nz && r_exeValid && (r_exeDest == bus.src1);
  assign w_m1M = w_src1Nz && r_memValid && (r_memDest == bus.src1);
  assign w_m1W = w_src1Nz && r_wbValid  && (r_wbDest  == bus.src1);
  assign w_m2E = w_src2Live && r_exeValid && (r_exeDest == bus.src2);
  assign w_m2M = w_src2Live && r_memValid && (r_memDest == bus.src2);
  assign w_m2W = w_src2Live && r_wbValid  && (r_wbDest  == bus.src2);

`ifdef FORWARD_EN
  // Youngest match wins. A load still in EXE has no result yet, so it stalls instead of forwarding.
  always_comb begin
    w_sel1 = 2'b00;
    w_sel2 = 2'b00;
    if (w_m1E)      w_sel1 = r_exeLoad ? 2'b00 : 2'b01;
    else if (w_m1M) w_sel1 = 2'b10;
    else if (w_m1W) w_sel1 = 2'b11;
    if (w_m2E)      w_sel2 = r_exeLoad ? 2'b00 : 2'b01;
    else if (w_m2M) w_sel2 = 2'b10;
    else if (w_m2W) w_sel2 = 2'b11;
  end

  assign w_stall = bus.id_valid && r_exeLoad && (w_m1E || w_m2E);

  logic w_unusedLoad;
  assign w_unusedLoad = ^{r_memLoad, r_wbLoad};
`else
  assign w_sel1  = 2'b00;
  assign w_sel2  = 2'b00;
  assign w_stall = bus.id_valid && (w_m1E || w_m1M || w_m1W || w_m2E || w_m2M || w_m2W);

  logic w_unusedLoad;
  assign w_unusedLoad = ^{r_exeLoad, r_memLoad, r_wbLoad};
`endif

  assign bus.stall        = w_stall;
  assign bus.fwd_sel1     = w_sel1;
  assign bus.fwd_sel2     = w_sel2;
  assign bus.stall_cycles = r_stallCnt;

  // Slots shift in lockstep with the pipeline. Stalled, flushed and non-writing instructions enter EXE as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exeValid <= 1'b0;
      r_exeDest  <= '0;
      r_exeLoad  <= 1'b0;
      r_memValid <= 1'b0;
      r_memDest  <= '0;
      r_memLoad  <= 1'b0;
      r_wbValid  <= 1'b0;
      r_wbDest   <= '0;
      r_wbLoad   <= 1'b0;
      r_stallCnt <= '0;
    end else if (!bus.freeze) begin
      r_wbValid  <= r_memValid;
      r_wbDest   <= r_memDest;
      r_wbLoad   <= r_memLoad;
      r_memValid <= r_exeValid;
      r_memDest  <= r_exeDest;
      r_memLoad  <= r_exeLoad;
      if (bus.id_valid && bus.id_WB_En && (bus.id_dest != '0) && !w_stall && !bus.flush) begin
        r_exeValid <= 1'b1;
        r_exeDest  <= bus.id_dest;
        r_exeLoad  <= bus.id_MEM_R_En;
      end else begin
        r_exeValid <= 1'b0;
        r_exeDest  <= '0;
        r_exeLoad  <= 1'b0;
      end
      if (w_stall && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a narrow 4-bit stall counter.
// Expected values follow FORWARD_EN. The default build has forwarding disabled.
module tb_hazard_scoreboard;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wb, input logic memR, input logic [4:0] dest,
                               input logic [4:0] s1, input logic [4:0] s2, input logic s2u,
                               input logic frz, input logic fls);
    bus.id_valid    = v;
    bus.id_WB_En    = wb;
    bus.id_MEM_R_En = memR;
    bus.id_dest     = dest;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.src2_used   = s2u;
    bus.freeze      = frz;
    bus.flush       = fls;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) stepClock();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepClock();
    stepClock();
    rst = 1'b0;
    #1;
    checkOutput("reset_stall", {15'd0, bus.stall}, 16'd0);
    checkOutput("reset_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    checkOutput("reset_fwd2", {14'd0, bus.fwd_sel2}, 16'd0);
    checkOutput("reset_cnt", {12'd0, bus.stall_cycles}, 16'd0);

    // A load writing r3, then its consumer.
    applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 0);
    checkOutput("lw_issue_stall", {15'd0, bus.stall}, 16'd0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 3, 0, 0, 0, 0);
    checkOutput("lu_stall", {15'd0, bus.stall}, 16'd1);
    checkOutput("lu_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    stepClock();
    checkOutput("lu_cnt", {12'd0, bus.stall_cycles}, 16'd1);
    checkOutput("lu_mem_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("lu_mem_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd2 : 16'd0);
    stepClock();
    drain();
    checkOutput("lu_cnt_after", {12'd0, bus.stall_cycles}, FWD ? 16'd1 : 16'd2);

    // An ALU write to r4, followed down the pipe.
    applyStimulus(1, 1, 0, 4, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
    checkOutput("alu_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("alu_fwd2", {14'd0, bus.fwd_sel2}, FWD ? 16'd1 : 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 4, 0, 0, 0);
    checkOutput("alu_s2unused_fwd2", {14'd0, bus.fwd_sel2}, 16'd0);
    checkOutput("alu_s2unused_stall", {15'd0, bus.stall}, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 0, 0);
    checkOutput("alu_mem_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd2 : 16'd0);
    checkOutput("alu_novalid_stall", {15'd0, bus.stall}, 16'd0);
    applyStimulus(1, 0, 0, 0, 4, 0, 0, 0, 0);
    checkOutput("alu_mem_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 0, 0);
    stepClock();
    checkOutput("alu_wb_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd3 : 16'd0);
    applyStimulus(1, 0, 0, 0, 4, 0, 0, 0, 0);
    checkOutput("alu_wb_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 0, 0);
    stepClock();
    checkOutput("alu_gone_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    drain();

    // Two writes to r5 in flight. The younger one must win.
    applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0);
    checkOutput("prio_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd1 : 16'd0);
    drain();

    // Writes to r0 are never recorded, and reads of r0 never match.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("r0_stall", {15'd0, bus.stall}, 16'd0);
    checkOutput("r0_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    drain();

    // A flushed write must not be tracked.
    applyStimulus(1, 1, 0, 7, 0, 0, 0, 0, 1);
    stepClock();
    applyStimulus(1, 0, 0, 0, 7, 0, 0, 0, 0);
    checkOutput("flush_stall", {15'd0, bus.stall}, 16'd0);
    checkOutput("flush_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    drain();

    // Load-use stall held under freeze, then released.
    applyStimulus(1, 1, 1, 6, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 6, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("frz_stall", {15'd0, bus.stall}, 16'd1);
      stepClock();
    end
    checkOutput("frz_cnt", {12'd0, bus.stall_cycles}, FWD ? 16'd1 : 16'd2);
    applyStimulus(1, 0, 0, 0, 6, 0, 0, 0, 0);
    checkOutput("frz_rel_stall", {15'd0, bus.stall}, 16'd1);
    stepClock();
    checkOutput("frz_rel_cnt", {12'd0, bus.stall_cycles}, FWD ? 16'd2 : 16'd3);
    checkOutput("frz_after_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("frz_after_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd2 : 16'd0);
    drain();

    // Fill all three slots, then reset while frozen.
    applyStimulus(1, 1, 0, 9, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 1, 0, 10, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 1, 0, 11, 0, 0, 0, 0, 0);
    stepClock();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    stepClock();
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 9, 11, 1, 0, 0);
    checkOutput("rst_stall", {15'd0, bus.stall}, 16'd0);
    checkOutput("rst_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);
    checkOutput("rst_fwd2", {14'd0, bus.fwd_sel2}, 16'd0);
    checkOutput("rst_cnt", {12'd0, bus.stall_cycles}, 16'd0);

    // A self-dependent load issued repeatedly keeps generating stalls, enough to saturate the 4-bit counter.
    applyStimulus(1, 1, 1, 12, 12, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) stepClock();
    checkOutput("sat_early_cnt", {12'd0, bus.stall_cycles}, FWD ? 16'd1 : 16'd2);
    for (int i = 0; i < 37; i++) stepClock();
    checkOutput("sat_cnt", {12'd0, bus.stall_cycles}, 16'hF);
    drain();
    checkOutput("sat_hold_cnt", {12'd0, bus.stall_cycles}, 16'hF);

    // An ALU write to r8 followed by a dependent read, cycle by cycle.
    applyStimulus(1, 1, 0, 8, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 8, 0, 0, 0, 0);
    checkOutput("r8_c1_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("r8_c1_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd1 : 16'd0);
    stepClock();
    checkOutput("r8_c2_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("r8_c2_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd2 : 16'd0);
    stepClock();
    checkOutput("r8_c3_stall", {15'd0, bus.stall}, FWD ? 16'd0 : 16'd1);
    checkOutput("r8_c3_fwd1", {14'd0, bus.fwd_sel1}, FWD ? 16'd3 : 16'd0);
    stepClock();
    checkOutput("r8_c4_stall", {15'd0, bus.stall}, 16'd0);
    checkOutput("r8_c4_fwd1", {14'd0, bus.fwd_sel1}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks in-flight register writes across the EXE, MEM and WB pipeline slots.
- Each cycle, produces the stall request and per-operand forward-select codes for the instruction in ID.
- Drives the forwarding datapath muxes and the ID/EXE stall logic.
- Sits beside the ID stage; slot contents advance in lockstep with the pipeline registers.

Parameters:
ADDR_W, 5, register address width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
freeze  input  1  memory-stall freeze; all pipeline registers hold
flush  input  1  branch taken; ID instruction killed
id_valid  input  1  ID holds a real instruction
id_WB_En  input  1  ID instruction writes the register file
id_MEM_R_En  input  1  ID instruction is a load
id_dest  input  ADDR_W  ID destination register
src1  input  ADDR_W  ID source 1
src2  input  ADDR_W  ID source 2
src2_used  input  1  src2 is read (not immediate, or BNE/store)
stall  output  1  hold PC/IF-ID, inject bubble into EXE
fwd_sel1  output  2  00 regfile, 01 EXE result, 10 MEM result, 11 WB result
fwd_sel2  output  2  same encoding for src2
stall_cycles  output  CNT_W  saturating count of stalled non-frozen cycles

Behaviour:
- State: three slot registers EXE, MEM, WB, each {valid, dest[ADDR_W], is_load}.
  - Reset: all valid=0, dest=0, is_load=0.
  - Reset: stall_cycles=0.
- Combinational outputs, computed from current slots and ID inputs, zero-latency:
  - stall=0 and fwd_sel=00 after reset until slots fill.
- Match rule: operand n matches slot S iff S.valid, S.dest==srcn, and srcn!=0.
  - src2 is considered only when src2_used=1.
- Priority is youngest first: EXE > MEM > WB.
  - fwd_seln = 01 / 10 / 11 for first match, else 00.
- Load-use hazard: first match is EXE with is_load=1 → stall=1 and that operand's fwd_sel=00.
  - A MEM-slot load match forwards normally (10).
- stall is gated by id_valid; if id_valid=0, stall=0.
- Advance on rising edge when freeze=0:
  - WB←MEM, MEM←EXE.
  - EXE←{1, id_dest, id_MEM_R_En} iff id_valid & id_WB_En & id_dest!=0 & !stall & !flush; else EXE←bubble (valid=0).
- freeze=1: all slots hold, counter holds; outputs still computed combinationally.
- flush and stall together: bubble enters EXE; stall still reported.
- stall_cycles increments when stall=1 & freeze=0; saturates at all-ones (no wrap).
- Reset mid-operation: all in-flight entries discarded next edge regardless of freeze/flush.
- Two in-flight writes to the same register: youngest slot wins per priority rule.
- Writes to r0 are never recorded; reads of r0 always select 00.

Optional Feature:
FORWARD_EN
- Defined: behaviour as above.
- Undefined: no forwarding.
  - fwd_sel1/fwd_sel2 tied to 00.
  - stall=1 whenever any used operand matches any valid EXE, MEM or WB slot (load or not).
  - Slot advance and counter rules unchanged.

Test Plan:
- Load-use: issue lw dest r3 (MEM_R_En=1); next cycle src1=r3 → stall=1, fwd_sel1=00, stall_cycles=1; following cycle (bubble in EXE, load in MEM) → stall=0, fwd_sel1=10.
- ALU chain: issue add dest r4; next cycle src2=r4, src2_used=1 → stall=0, fwd_sel2=01.
  - Same with src2_used=0 → fwd_sel2=00.
  - Two cycles later, src1=r4 → fwd_sel1=10; three cycles later → 11; four cycles later → 00.
- Priority/r0: issue add r5, then sub r5; next cycle src1=r5 → 01 (younger).
  - Issue with dest r0, then src1=r0 → 00, stall=0.
- Freeze: load r6 in EXE, src1=r6, freeze=1 for 5 cycles → stall=1 throughout, slots unchanged, stall_cycles unchanged.
  - After release → one counted stall, then fwd_sel1=10.
- Flush/reset: issue add r7 with flush=1 → next cycle src1=r7 gives 00.
  - Fill all slots then assert rst one cycle → all fwd_sel=00, stall=0, stall_cycles=0.
- Saturation: hold a load-use stall for 2^CNT_W+3 cycles (test with CNT_W=4 → 19 cycles) → stall_cycles stays 0xF.
  - Without FORWARD_EN: add r8 then src1=r8 → stall=1 for 3 cycles, fwd_sel1=00 throughout.
